// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 2-bit add/subtract ALU.
//   OP_ADD / OP_SUB : encodings of the operation select input
//   ALU_W           : operand and result width
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int   ALU_W  = 2;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/fulladdr.sv
// ---------------------------------------------------------------------------
// fulladdr
// One-bit full adder primitive.
//   a, b : addend bits
//   cin  : carry in
//   sum  : a ^ b ^ cin
//   cout : carry out
// ---------------------------------------------------------------------------
module fulladdr (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ cin;
    // Carry is generated by a&b or propagated from cin when exactly one of a/b is set.
    assign cout     = (a & b) | (cin & half_sum);

endmodule : fulladdr

// File: rtl/mux2_1.sv
// ---------------------------------------------------------------------------
// mux2_1
// One-bit 2:1 multiplexer primitive.
//   d0  : selected when sel = 0
//   d1  : selected when sel = 1
//   sel : select
//   y   : output
// ---------------------------------------------------------------------------
module mux2_1 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule : mux2_1

// File: rtl/alu_2bit.sv
// ---------------------------------------------------------------------------
// alu_2bit
// Two-bit add/subtract ALU with a registered result and carry-out.
// A ripple of two full adders computes A + (C ? ~B : B) + C; the 3-bit sum
// is captured in output flops one clock later.
//   clk : clock, rising edge active
//   rst : asynchronous active-high reset, clears D and E immediately
//   A   : operand A (2 bits)
//   B   : operand B (2 bits)
//   C   : operation select, OP_ADD (0) or OP_SUB (1)
//   D   : registered 2-bit result
//   E   : registered carry-out of the MSB adder
//         (add: unsigned overflow; subtract: 1 = no borrow, i.e. A >= B)
// ---------------------------------------------------------------------------
module alu_2bit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic             C,
    output logic [ALU_W-1:0] D,
    output logic             E
);

    logic             sub_sel;
    logic [ALU_W-1:0] b_inv;
    logic [ALU_W-1:0] b_sel;
    logic [ALU_W-1:0] sum_c;
    logic [ALU_W:0]   carry;

    logic [ALU_W-1:0] result_p1;
    logic             carry_p1;

    assign sub_sel = (C == OP_SUB);
    assign b_inv   = ~B;
    // Subtract is A + ~B + 1: the "+1" enters as carry-in of bit 0.
    assign carry[0] = sub_sel;

    // ---- stage 0: operand select and ripple-carry add ----
    for (genvar i = 0; i < ALU_W; i++) begin : g_bit
        mux2_1 u_bsel (
            .d0  (B[i]),
            .d1  (b_inv[i]),
            .sel (sub_sel),
            .y   (b_sel[i])
        );

        fulladdr u_fa (
            .a    (A[i]),
            .b    (b_sel[i]),
            .cin  (carry[i]),
            .sum  (sum_c[i]),
            .cout (carry[i+1])
        );
    end : g_bit

    // ---- stage 1: output registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_p1 <= '0;
            carry_p1  <= 1'b0;
        end else begin
            result_p1 <= sum_c;
            carry_p1  <= carry[ALU_W];
        end
    end

    assign D = result_p1;
    assign E = carry_p1;

endmodule : alu_2bit

// File: tb/tb_alu_2bit.sv
// ---------------------------------------------------------------------------
// tb_alu_2bit
// Self-checking bench for alu_2bit. Inputs are driven on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_2bit;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] A;
    logic [1:0] B;
    logic       C;
    logic [1:0] D;
    logic       E;

    int cnt_cmp;
    int cnt_fail;

    alu_2bit dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D),
        .E   (E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       c;
        logic [1:0] d;
        logic       e;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    // Reference: arithmetic meaning of each operation, not the adder structure.
    function automatic logic [2:0] ref_op(input logic [1:0] a, input logic [1:0] b,
                                          input logic c);
        int ai;
        int bi;
        int r;
        ai = int'(a);
        bi = int'(b);
        if (c == OP_ADD)
            r = ai + bi;
        else
            r = ((ai >= bi) ? 4 : 0) + ((ai - bi + 4) % 4);
        return 3'(r);
    endfunction

    task automatic check(input string name, input logic [1:0] d_exp, input logic e_exp);
        cnt_cmp++;
        if (D !== d_exp || E !== e_exp) begin
            cnt_fail++;
            $display("FAIL %s: got D=%b E=%b, want D=%b E=%b", name, D, E, d_exp, e_exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic c);
        A = a;
        B = b;
        C = c;
    endtask

    initial begin
        logic [2:0] exp_r;
        logic [2:0] prev_r;
        logic [4:0] combo;

        cnt_cmp  = 0;
        cnt_fail = 0;

        // Add sweep, subtract sweep, then the mode toggle pair.
        vecs[0]  = '{2'b01, 2'b10, OP_ADD, 2'b11, 1'b0};
        vecs[1]  = '{2'b00, 2'b10, OP_ADD, 2'b10, 1'b0};
        vecs[2]  = '{2'b11, 2'b01, OP_ADD, 2'b00, 1'b1};
        vecs[3]  = '{2'b11, 2'b11, OP_ADD, 2'b10, 1'b1};
        vecs[4]  = '{2'b01, 2'b01, OP_SUB, 2'b00, 1'b1};
        vecs[5]  = '{2'b01, 2'b10, OP_SUB, 2'b11, 1'b0};
        vecs[6]  = '{2'b10, 2'b01, OP_SUB, 2'b01, 1'b1};
        vecs[7]  = '{2'b00, 2'b11, OP_SUB, 2'b01, 1'b0};
        vecs[8]  = '{2'b01, 2'b11, OP_SUB, 2'b10, 1'b0};
        vecs[9]  = '{2'b10, 2'b10, OP_ADD, 2'b00, 1'b1};
        vecs[10] = '{2'b10, 2'b10, OP_SUB, 2'b00, 1'b1};

        // Reset asserted between edges must clear outputs without a clock.
        rst = 1'b0;
        drive(2'b11, 2'b11, OP_ADD);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", 2'b00, 1'b0);
        @(posedge clk); #1;
        check("reset_hold1", 2'b00, 1'b0);
        @(posedge clk); #1;
        check("reset_hold2", 2'b00, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        // Directed table; between edges the previous result must still be held.
        prev_r = 3'b000;
        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].c);
            #1;
            check($sformatf("vec%0d_hold", i), prev_r[1:0], prev_r[2]);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].d, vecs[i].e);
            prev_r = {vecs[i].e, vecs[i].d};
        end

        // Mid-stream reset pulse between edges.
        @(negedge clk);
        drive(2'b01, 2'b10, OP_ADD);
        @(posedge clk); #1;
        check("mid_pre", 2'b11, 1'b0);
        @(negedge clk);
        drive(2'b11, 2'b01, OP_ADD);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_async", 2'b00, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_released", 2'b00, 1'b0);
        @(posedge clk); #1;
        check("mid_post", 2'b00, 1'b1);

        // Exhaustive sweep of all 32 input combinations.
        for (int k = 0; k < 32; k++) begin
            combo = 5'(k);
            @(negedge clk);
            drive(combo[4:3], combo[2:1], combo[0]);
            exp_r = ref_op(combo[4:3], combo[2:1], combo[0]);
            @(posedge clk); #1;
            check($sformatf("exh_a%b_b%b_c%b", combo[4:3], combo[2:1], combo[0]),
                  exp_r[1:0], exp_r[2]);
        end

        // Randomized back-to-back operations.
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            drive(2'($urandom), 2'($urandom), 1'($urandom));
            exp_r = ref_op(A, B, C);
            @(posedge clk); #1;
            check($sformatf("rnd%0d", k), exp_r[1:0], exp_r[2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_2bit
